// File: rtl/seq2_fetch_pkg.sv
// Shared encodings and widths for the two-cycle instruction fetch controller.
// State encoding is 3 bits; address, instruction and issue-count widths live here.
package seq2_fetch_pkg;

   localparam int ADDR_W = 8;
   localparam int INST_W = 20;
   localparam int ICNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEQRST  = 3'd1,
      ST_SEQWAIT = 3'd2,
      ST_FETCH   = 3'd3,
      ST_EXEC    = 3'd4,
      ST_BREAK   = 3'd5
   } state_t;

   localparam logic [ICNT_W-1:0] ICNT_MAX = '1;
   localparam logic [ICNT_W-1:0] ICNT_ONE = {{(ICNT_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/seq2_fetch.sv
// Fetch/issue controller: host loads external RAM in Idle, then one instruction per 2 cycles with breakpoint.
// Latency: RAM address in Fetch, instruction issued in Exec; no backpressure, halt/run pulses steer the FSM.
module seq2_fetch
   import seq2_fetch_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_run,
   input  logic              i_halt,
   input  logic [ADDR_W-1:0] i_host_addr,
   input  logic [INST_W-1:0] i_host_data,
   input  logic              i_host_wen,
   input  logic [ADDR_W-1:0] i_bp_addr,
   input  logic              i_bp_en,
   input  logic [ADDR_W-1:0] i_seq_next,
   input  logic [INST_W-1:0] i_mem_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [INST_W-1:0] o_mem_wdata,
   output logic              o_mem_wen,
   output logic [INST_W-1:0] o_inst,
   output logic              o_inst_en,
   output logic              o_seq_reset,
   output logic              o_busy,
   output logic [ICNT_W-1:0] o_icount,
   output logic              o_wr_err
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ICNT_W-1:0]   r_icount;
   logic                r_wr_err;
   logic                w_start;
   logic                w_bp_hit;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [INST_W-1:0]   w_mem_wdata;
   logic                w_mem_wen;
   logic [INST_W-1:0]   w_inst;
   logic                w_inst_en;
   logic                w_seq_reset;

   assign w_start  = (r_state == ST_IDLE) && i_run && !i_halt;
   assign w_bp_hit = i_bp_en && (i_seq_next == i_bp_addr);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_start) w_state_nxt = ST_SEQRST;
         ST_SEQRST:  w_state_nxt = i_halt ? ST_IDLE : ST_SEQWAIT;
         ST_SEQWAIT: w_state_nxt = i_halt ? ST_IDLE : ST_FETCH;
         ST_FETCH:   w_state_nxt = i_halt ? ST_IDLE : (w_bp_hit ? ST_BREAK : ST_EXEC);
         ST_EXEC:    w_state_nxt = i_halt ? ST_IDLE : ST_FETCH;
         // Resuming skips the breakpoint test so the held address can issue.
         ST_BREAK:   w_state_nxt = i_halt ? ST_IDLE : (i_run ? ST_EXEC : ST_BREAK);
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_mem_wen   = 1'b0;
      w_inst      = '0;
      w_inst_en   = 1'b0;
      w_seq_reset = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_mem_addr  = i_host_addr;
            w_mem_wdata = i_host_data;
            w_mem_wen   = i_host_wen;
         end
         ST_SEQRST: w_seq_reset = 1'b1;
         // Break keeps the address on the RAM so a resume finds its data ready.
         ST_FETCH, ST_BREAK: w_mem_addr = i_seq_next;
         ST_EXEC: begin
            w_inst    = i_mem_rdata;
            w_inst_en = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_icount <= '0;
      end else if (w_start) begin
         r_icount <= '0;
      end else if ((r_state == ST_EXEC) && (r_icount != ICNT_MAX)) begin
         r_icount <= r_icount + ICNT_ONE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_err <= 1'b0;
      end else if (i_host_wen && (r_state != ST_IDLE)) begin
         r_wr_err <= 1'b1;
      end
   end

   // Combinational outputs are forced while reset is low, not just at the next edge.
   assign o_mem_addr  = i_rst_n ? w_mem_addr  : '0;
   assign o_mem_wdata = i_rst_n ? w_mem_wdata : '0;
   assign o_mem_wen   = i_rst_n & w_mem_wen;
   assign o_inst      = i_rst_n ? w_inst : '0;
   assign o_inst_en   = i_rst_n & w_inst_en;
   assign o_seq_reset = ~i_rst_n | w_seq_reset;
   assign o_busy      = i_rst_n & (r_state != ST_IDLE);
   assign o_icount    = r_icount;
   assign o_wr_err    = r_wr_err;

endmodule

// File: tb/tb_seq2_fetch.sv
// Bench for seq2_fetch: external sync RAM and sequencer models, table vectors, directed sequences, random programs.
module tb_seq2_fetch;
   import seq2_fetch_pkg::*;

   localparam logic [19:0] NO  = 20'h00000;
   localparam logic [19:0] JI0 = 20'h40000;
   localparam int          M   = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run, halt, host_wen, bp_en;
   logic [7:0]  host_addr, bp_addr;
   logic [19:0] host_data;
   logic [7:0]  seq_next = 8'h00;
   logic [19:0] mem_rdata = 20'h0;
   logic [7:0]  mem_addr;
   logic [19:0] mem_wdata;
   logic        mem_wen;
   logic [19:0] inst;
   logic        inst_en, seq_reset, busy, wr_err;
   logic [15:0] icount;

   int total = 0;
   int bad   = 0;

   logic [19:0] ram  [256];
   logic [19:0] prog [256];
   logic [19:0] exp_q[$];
   logic [7:0]  exp_a[$];
   logic [19:0] got_q[$];
   int          got_c[$];

   typedef struct {
      logic        wen;
      logic [7:0]  addr;
      logic [19:0] data;
      logic        hlt;
      logic        e_wen;
      logic [7:0]  e_addr;
      logic [19:0] e_wdata;
      logic        e_busy;
   } vec_t;
   vec_t tbl[4];

   always #5 clk = ~clk;

   seq2_fetch dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_halt(halt),
      .i_host_addr(host_addr), .i_host_data(host_data), .i_host_wen(host_wen),
      .i_bp_addr(bp_addr), .i_bp_en(bp_en), .i_seq_next(seq_next),
      .i_mem_rdata(mem_rdata), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_mem_wen(mem_wen), .o_inst(inst), .o_inst_en(inst_en),
      .o_seq_reset(seq_reset), .o_busy(busy), .o_icount(icount), .o_wr_err(wr_err)
   );

   function automatic logic is_ji(input logic [19:0] w);
      return w[19:16] == 4'h4;
   endfunction

   always @(posedge clk) begin
      if (mem_wen) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   always @(posedge clk) begin
      if (seq_reset) seq_next <= 8'h00;
      else if (inst_en) seq_next <= is_ji(inst) ? inst[7:0] : seq_next + 8'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [19:0] d);
      @(posedge clk); #1;
      host_wen = 1'b1; host_addr = a; host_data = d;
   endtask

   task automatic wr_end();
      @(posedge clk); #1;
      host_wen = 1'b0;
   endtask

   task automatic pulse_run();
      @(posedge clk); #1;
      run = 1'b1;
      @(negedge clk);
   endtask

   // Walks the program as the spec describes it: issue, then jump or step, stopping at a breakpoint.
   task automatic model(input logic en, input logic [7:0] bp);
      logic [7:0] pc;
      pc = 8'h00;
      exp_q.delete();
      exp_a.delete();
      for (int i = 0; i < M; i++) begin
         if (en && pc == bp) break;
         exp_q.push_back(prog[pc]);
         exp_a.push_back(pc);
         pc = is_ji(prog[pc]) ? prog[pc][7:0] : pc + 8'd1;
      end
   endtask

   initial begin
      logic [19:0] w;
      int t;
      int n;
      tbl[0] = '{1'b1, 8'h00, 20'h10A05, 1'b0, 1'b1, 8'h00, 20'h10A05, 1'b0};
      tbl[1] = '{1'b0, 8'h5A, 20'hFFFFF, 1'b1, 1'b0, 8'h5A, 20'hFFFFF, 1'b0};
      tbl[2] = '{1'b1, 8'hFF, 20'h00001, 1'b1, 1'b1, 8'hFF, 20'h00001, 1'b0};
      tbl[3] = '{1'b0, 8'h33, 20'h12345, 1'b0, 1'b0, 8'h33, 20'h12345, 1'b0};

      rst_n = 1'b0; run = 1'b0; halt = 1'b0; host_wen = 1'b0;
      host_addr = 8'h44; host_data = 20'h55555; bp_en = 1'b0; bp_addr = 8'h00;
      #2;
      chk("rst_seq_reset", seq_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_inst_en", inst_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_icount", icount, 0);
      chk("rst_wr_err", wr_err, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle pass-through, halt ignored in Idle
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         host_wen = tbl[i].wen; host_addr = tbl[i].addr;
         host_data = tbl[i].data; halt = tbl[i].hlt;
         @(negedge clk);
         chk("tbl_mem_wen", mem_wen, tbl[i].e_wen);
         chk("tbl_mem_addr", mem_addr, tbl[i].e_addr);
         chk("tbl_mem_wdata", mem_wdata, tbl[i].e_wdata);
         chk("tbl_busy", busy, tbl[i].e_busy);
         chk("tbl_wr_err", wr_err, 0);
      end
      @(posedge clk); #1;
      host_wen = 1'b0; halt = 1'b0;

      // NO, NO, JI 0x00 with halt in an Exec cycle
      wr(8'h00, NO); wr(8'h01, NO); wr(8'h02, JI0); wr_end();
      pulse_run();
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         run = (k == 6); halt = (k == 10);
         @(negedge clk);
         if (k <= 9) begin
            chk("p1_seq_reset", seq_reset, (k == 1));
            chk("p1_inst_en", inst_en, (k == 4 || k == 6 || k == 8));
         end
         if (k == 5) chk("p1_inst_zero", inst, 0);
         if (k == 8) chk("p1_inst_ji", inst, JI0);
         if (k == 9) chk("p1_icount3", icount, 3);
         if (k == 10) chk("p1_halt_exec_en", inst_en, 1);
         if (k == 11) begin
            chk("p1_halt_busy", busy, 0);
            chk("p1_halt_icount", icount, 4);
         end
      end
      @(posedge clk); #1;
      halt = 1'b0;

      // Breakpoint, resume, rejected host write, run+halt in Break
      bp_addr = 8'h02; bp_en = 1'b1; host_addr = 8'h80; host_data = 20'hABCDE;
      pulse_run();
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk); #1;
         run = (k == 12 || k == 20); halt = (k == 20); host_wen = (k == 14);
         @(negedge clk);
         if (k == 8) begin
            chk("bp_inst_en", inst_en, 0);
            chk("bp_busy", busy, 1);
            chk("bp_icount", icount, 2);
            chk("bp_mem_addr", mem_addr, 8'h02);
         end
         if (k == 11) chk("bp_hold", inst_en, 0);
         if (k == 13) begin
            chk("resume_en", inst_en, 1);
            chk("resume_inst", inst, JI0);
         end
         if (k == 14) chk("fetch_wen_drop", mem_wen, 0);
         if (k == 15) begin
            chk("wr_err_set", wr_err, 1);
            chk("resume_cont", inst_en, 1);
         end
         if (k == 19) begin
            chk("bp2_icount", icount, 5);
            chk("bp2_inst_en", inst_en, 0);
         end
         if (k == 21) chk("runhalt_busy", busy, 0);
      end
      @(posedge clk); #1;
      run = 1'b0; halt = 1'b0; host_wen = 1'b0; bp_en = 1'b0;
      chk("wr_err_sticky", wr_err, 1);

      // Reset in the middle of an Exec cycle
      pulse_run();
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         run = 1'b0;
      end
      @(posedge clk); #1;
      chk("pre_rst_en", inst_en, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_en", inst_en, 0);
      chk("mid_rst_inst", inst, 0);
      chk("mid_rst_seq_reset", seq_reset, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_icount", icount, 0);
      chk("mid_rst_wr_err", wr_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      host_wen = 1'b1; host_addr = 8'h21; host_data = 20'h0F0F0;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_wen", mem_wen, 1);
      @(posedge clk); #1;
      host_wen = 1'b0;

      // Random programs against the reference walk
      for (int it = 0; it < 12; it++) begin
         for (int a = 0; a < 256; a++) begin
            w = 20'($urandom);
            if ($urandom_range(0, 3) == 0) begin
               t = $urandom_range(0, 255);
               w = JI0 | {12'h000, t[7:0]};
            end else if (w[19:16] == 4'h4) begin
               w[19:16] = 4'h5;
            end
            prog[a] = w;
         end
         if (it % 2 == 0) begin
            prog[0] = JI0 | 20'h000FE;
            if (is_ji(prog[8'hFE])) prog[8'hFE] = NO;
            if (is_ji(prog[8'hFF])) prog[8'hFF] = NO;
         end
         for (int a = 0; a < 256; a++) wr(a[7:0], prog[a]);
         wr_end();
         model(1'b0, 8'h00);
         bp_en   = ($urandom_range(0, 1) == 1);
         bp_addr = exp_a[$urandom_range(1, M - 1)];
         model(bp_en, bp_addr);
         got_q.delete();
         got_c.delete();
         pulse_run();
         for (int k = 1; k <= 2 * M + 2; k++) begin
            @(posedge clk); #1;
            run = 1'b0;
            @(negedge clk);
            if (inst_en) begin
               got_q.push_back(inst);
               got_c.push_back(k);
            end else begin
               chk("rnd_inst_zero", inst, 0);
            end
         end
         @(posedge clk); #1;
         halt = 1'b1;
         @(negedge clk);
         chk("rnd_icount", icount, exp_q.size());
         chk("rnd_count", got_q.size(), exp_q.size());
         n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
         for (int i = 0; i < n; i++) begin
            chk("rnd_inst", got_q[i], exp_q[i]);
            chk("rnd_cycle", got_c[i], 4 + 2 * i);
         end
         @(posedge clk); #1;
         halt = 1'b0; bp_en = 1'b0;
         @(negedge clk);
         chk("rnd_idle", busy, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
